// File: rtl/wb_commit_unit_pkg.sv
// ----------------------------------------------------------------------------
// wb_commit_unit_pkg
//
// Shared constants for the write-back commit unit and its round-robin
// arbiter: default data width and register count, the source index
// encoding used by the arbiter, and a helper that advances a source
// index in the ALU -> LSU -> MDU -> ALU rotation.
//
// No ports (package).
// ----------------------------------------------------------------------------
package wb_commit_unit_pkg;

  // Core-wide defaults; the top level exposes these as overridable parameters.
  localparam int XLEN = 32;
  localparam int NREG = 32;

  // Register address width (x0..x31).
  localparam int REG_AW = 5;

  // Number of result producers competing for the write port.
  localparam int NSRC = 3;

  // Source index encoding; also the bit position of each source in the
  // request and grant vectors.
  typedef logic [1:0] src_idx_t;

  localparam src_idx_t SRC_ALU = 2'd0;
  localparam src_idx_t SRC_LSU = 2'd1;
  localparam src_idx_t SRC_MDU = 2'd2;

  // Next source in the rotation; MDU wraps back to ALU.
  function automatic src_idx_t next_src(input src_idx_t src);
    src_idx_t nxt;
    if (src == SRC_MDU) begin
      nxt = SRC_ALU;
    end else begin
      nxt = src + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Three-request round-robin arbiter. The grant is combinational: the search
// starts at the rotating pointer and takes the first asserted request in
// ALU -> LSU -> MDU order. After a grant to source i the pointer moves to
// the source after i; with no grant it holds.
//
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous active-low reset (pointer returns to ALU)
//   req[2:0]    in   request per source, bit index = source index
//   grant[2:0]  out  one-hot grant, same bit order as req
//   grant_valid out  some request was granted this cycle
//   grant_idx   out  index of the granted source (pointer when no grant)
// ----------------------------------------------------------------------------
module wb_rr_arbiter
  import wb_commit_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_idx
);

  src_idx_t ptr;
  src_idx_t cand;

  // Walk the three sources starting at the pointer; the first request seen
  // wins. grant_idx defaults to the pointer so it is never X.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = ptr;
    cand        = ptr;
    for (int k = 0; k < NSRC; k++) begin
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
      cand = next_src(cand);
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer only moves on a grant, and then to the source after the winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= SRC_ALU;
    end else if (grant_valid) begin
      ptr <= next_src(grant_idx);
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// ----------------------------------------------------------------------------
// wb_commit_unit
//
// Write side of the integer register file. Three producers (ALU, LSU, MDU)
// offer results over valid/ready; a round-robin arbiter accepts one per
// cycle and the accepted result is written through a registered port
// (rd_en/rd_addr/rd_data) one cycle later. A busy scoreboard tracks
// registers with in-flight writes so decode can stall on RAW hazards.
//
// Optional feature macro: WB_BYPASS_EN
//   Adds rs1/rs2 forwarding outputs taken from the write port; a register
//   that is being forwarded reports busy=0 so decode does not stall.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   issue_valid, issue_rd         destination of an issuing instruction
//   flush                         clears the scoreboard
//   {alu,lsu,mdu}_valid/rd/data   producer results
//   {alu,lsu,mdu}_ready           result accepted this cycle
//   rd_en, rd_addr, rd_data       register-file write port (registered)
//   rs1_addr, rs2_addr            decode read addresses
//   rs1_busy, rs2_busy            operand has a pending write
//   rs1/rs2_fwd_valid/data        forwarding (WB_BYPASS_EN only)
// ----------------------------------------------------------------------------
module wb_commit_unit #(
  parameter int XLEN = wb_commit_unit_pkg::XLEN,
  parameter int NREG = wb_commit_unit_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            flush,

  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,

  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,

  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,

  output logic            rd_en,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,

  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy
`ifdef WB_BYPASS_EN
  ,
  output logic            rs1_fwd_valid,
  output logic            rs2_fwd_valid,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic [XLEN-1:0] rs2_fwd_data
`endif
);

  import wb_commit_unit_pkg::*;

  logic [2:0]      req;
  logic [2:0]      grant;
  logic            grant_valid;
  logic [1:0]      grant_idx;
  logic            transfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            rs1_pending;
  logic            rs2_pending;

  assign req = {mdu_valid, lsu_valid, alu_valid};

  wb_rr_arbiter u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Nothing is accepted while reset is held, even with valids asserted, so
  // a result offered during reset is simply re-offered afterwards.
  assign alu_ready = grant[SRC_ALU] & rst_n;
  assign lsu_ready = grant[SRC_LSU] & rst_n;
  assign mdu_ready = grant[SRC_MDU] & rst_n;
  assign transfer  = grant_valid & rst_n;

  // Result mux for the winning source.
  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    case (grant_idx)
      SRC_LSU: begin
        sel_rd   = lsu_rd;
        sel_data = lsu_data;
      end
      SRC_MDU: begin
        sel_rd   = mdu_rd;
        sel_data = mdu_data;
      end
      default: begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
      end
    endcase
  end

  // Registered write port. A write to x0 is accepted from the source but
  // never reaches the register file; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else if (transfer && (sel_rd != 5'd0)) begin
      rd_en   <= 1'b1;
      rd_addr <= sel_rd;
      rd_data <= sel_data;
    end else begin
      rd_en   <= 1'b0;
    end
  end

  // Scoreboard next state. Clear happens on the commit edge; a same-edge
  // issue to that register re-sets it (set wins); flush beats everything.
  always_comb begin
    busy_next = busy;
    if (rd_en) begin
      busy_next[rd_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign rs1_pending = (rs1_addr != 5'd0) & busy[rs1_addr];
  assign rs2_pending = (rs2_addr != 5'd0) & busy[rs2_addr];

`ifdef WB_BYPASS_EN
  // The register being committed this cycle can be forwarded to decode
  // directly, so it does not need to stall even though busy is still set.
  assign rs1_fwd_valid = rd_en & (rd_addr == rs1_addr) & (rs1_addr != 5'd0);
  assign rs2_fwd_valid = rd_en & (rd_addr == rs2_addr) & (rs2_addr != 5'd0);
  assign rs1_fwd_data  = rd_data;
  assign rs2_fwd_data  = rd_data;
  assign rs1_busy      = rs1_pending & ~rs1_fwd_valid;
  assign rs2_busy      = rs2_pending & ~rs2_fwd_valid;
`else
  assign rs1_busy      = rs1_pending;
  assign rs2_busy      = rs2_pending;
`endif

`ifndef SYNTHESIS
  // Decode must stall on WAW; issuing to a still-busy register is illegal
  // unless that register is committing on this very edge or being flushed.
  always_ff @(posedge clk) begin
    if (rst_n && issue_valid && (issue_rd != 5'd0) && !flush &&
        !(rd_en && (rd_addr == issue_rd))) begin
      assert (!busy[issue_rd]);
    end
  end
`endif

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Write side of the integer register file (x0-x31).
- Arbitrates results from three producers (ALU, LSU, MDU) over valid/ready handshakes and drives a registered write port: rd_en, rd_addr, rd_data.
- Holds a busy scoreboard of registers with in-flight writes, so decode can stall on RAW hazards against register-file reads.
- Sits between the execute units and the register file; decode and issue drive the scoreboard.

Parameters:
- XLEN, 32, data width; matches the core-wide XLEN from config.v.
- NREG, 32, number of architectural registers; x0 is hardwired zero.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- issue_valid  in  1  an instruction with a destination register issues this cycle
- issue_rd  in  5  destination register of the issuing instruction
- flush  in  1  pipeline flush; clears the scoreboard
- alu_valid / lsu_valid / mdu_valid  in  1 each  source has a result
- alu_rd / lsu_rd / mdu_rd  in  5 each  result destination
- alu_data / lsu_data / mdu_data  in  XLEN each  result value
- alu_ready / lsu_ready / mdu_ready  out  1 each  result accepted this cycle
- rd_en  out  1  register-file write enable
- rd_addr  out  5  register-file write address
- rd_data  out  XLEN  register-file write data
- rs1_addr, rs2_addr  in  5 each  decode read addresses
- rs1_busy, rs2_busy  out  1 each  operand has a pending write

Behaviour:
- Reset: clk is the clock; rst_n is a synchronous, active-low reset. While rst_n=0: rd_en=0, rd_addr=0, rd_data=0, busy[31:0]=0, round-robin pointer=ALU. Reset mid-transfer drops any pending write.
- Arbitration: combinational, round-robin among asserted valids, in the order ALU -> LSU -> MDU -> ALU. The search starts at the pointer.
  - Exactly one source is granted per cycle; its ready is high in that same cycle. A transfer occurs when valid & ready.
  - After a grant to source i, the pointer moves to i+1 mod 3. With no grant, the pointer holds.
  - ready is low for every non-granted source.
- Sources hold valid, rd and data stable until accepted. Deasserting valid before acceptance is legal (ALU kill).
- Output latency is 1 cycle: the edge after a transfer, rd_en<=1 and rd_addr/rd_data<=granted values.
  - With no transfer, rd_en<=0 and rd_addr/rd_data hold their last value.
  - Back-to-back transfers give rd_en high on consecutive cycles.
- Transfer with rd=0: it is accepted (ready=1), but rd_en stays 0 and the scoreboard is untouched.
- Scoreboard:
  - Set: busy[issue_rd]<=1 when issue_valid & issue_rd!=0.
  - Clear: busy[rd_addr]<=0 on the edge where rd_en=1, i.e. the same edge the register file commits. A reader therefore never sees busy=0 with stale file data.
  - Set and clear of the same register on the same edge: set wins.
  - Issue to a register that is already busy is illegal (decode stalls on WAW). This is checked by a simulation assertion, not handled in RTL.
  - busy[0] is always 0.
- flush: busy<=0 on the next edge, and flush overrides a same-cycle issue. Arbitration and the output register are unaffected; sources must kill their own flushed results.
- rsN_busy = busy[rsN_addr], combinational; 0 when rsN_addr=0.

Optional Feature:
- WB_BYPASS_EN defined adds outputs rs1_fwd_valid and rs2_fwd_valid (1 bit each) and rs1_fwd_data and rs2_fwd_data (XLEN each).
  - rsN_fwd_valid = rd_en & rd_addr==rsN_addr & rsN_addr!=0, with rsN_fwd_data=rd_data.
  - In that case rsN_busy is forced to 0, so decode takes the forwarded value instead of stalling.
- WB_BYPASS_EN undefined: these ports are absent and rsN_busy behaves as above, costing one extra stall cycle versus bypass.

Decomposition:
- Shared package/config: XLEN, NREG, and source index constants SRC_ALU=0, SRC_LSU=1, SRC_MDU=2.
- One sub-module, wb_rr_arbiter: 3-request round-robin with pointer state, one-hot grant, grant_valid.
- Top level holds the output register, the scoreboard and the bypass logic.

Test Plan:
- Reset: hold rst_n=0 with all valids high -> readys 0, rd_en=0, rd_addr=0, rd_data=0, rs1_busy=0 for rs1_addr=5.
- Basic: issue rd=5; next cycle rs1_busy=1. Then alu_valid rd=5 data=0xDEADBEEF -> alu_ready=1 that cycle, next cycle rd_en=1 rd_addr=5 rd_data=0xDEADBEEF, cycle after rs1_busy=0.
- Fairness: pointer=ALU, all three valid for 3 cycles -> grants ALU, LSU, MDU in order; rd_en high 3 consecutive cycles; pointer ends at ALU.
- x0 write: lsu_valid rd=0 data=0x1234 -> lsu_ready=1; rd_en stays 0; no busy bit changes.
- Set/clear collision: busy[7]=1 with rd_en=1 rd_addr=7, and issue rd=7 on the same edge -> busy[7] remains 1.
- Flush and bypass: busy 3 and 9 set, flush=1 -> both 0 next cycle. With WB_BYPASS_EN defined, rd_en=1 rd_addr=9 rd_data=0xA5A5A5A5 and rs2_addr=9 -> rs2_fwd_valid=1, rs2_fwd_data=0xA5A5A5A5, rs2_busy=0.
